mac_unit_pipelined: RTL and testbench

Parametrised, two-stage pipelined multiply-accumulate unit computing fixed-length dot products over a valid/ready stream of operand pairs. Each accepted pair (a, b) is multiplied, then accumulated. After LEN pairs the sum is presented on a held output register with its own valid/ready handshake, and the accumulator restarts for the next vector. Operand signedness and overflow handling (wrap or saturate) are build-time modes. It replaces the fixed 2-bit MAC as the compute element of the datapath.

---
 rtl/mac_unit_pipelined.sv | 153 +++++++++++++++
 tb/tb_mac_unit_pipelined.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_unit_pipelined.sv
// Two-stage pipelined multiply-accumulate unit producing fixed-length dot products
// over a valid/ready operand stream, with a held, handshaked result register.
module mac_unit_pipelined #(
   parameter int IN_WIDTH  = 8,
   parameter int ACC_WIDTH = 24,
   parameter int LEN       = 8,
   parameter int SIGNED    = 0,
   parameter int SATURATE  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  a,
   input  logic [IN_WIDTH-1:0]  b,
   input  logic                 clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out,
   output logic                 overflow
);

   localparam int PW = 2 * IN_WIDTH;
   localparam int CW = 16;
   localparam int M  = ACC_WIDTH - 1;
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);

   logic [PW-1:0]        p_q, p_d;
   logic                 p_valid_q, p_valid_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 ovf_acc_q, ovf_acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [ACC_WIDTH-1:0] out_q, out_d;
   logic                 overflow_q, overflow_d;
   logic                 out_valid_q, out_valid_d;

   logic                 adv;
   logic                 accept;
   logic                 sx;
   logic [PW-1:0]        a_ext, b_ext, prod;
   logic [ACC_WIDTH:0]   p_ext, acc_ext, sum;
   logic                 ovf;
   logic [ACC_WIDTH-1:0] sat_val, res;

   // Handshake, product and accumulate datapath
   always_comb begin
      adv      = !(out_valid_q && !out_ready);
      in_ready = adv && !clear && !reset;
      accept   = in_valid && in_ready;

      // The low PW bits of the extended product are correct for both signednesses
      a_ext = {{IN_WIDTH{(SIGNED != 0) && a[IN_WIDTH-1]}}, a};
      b_ext = {{IN_WIDTH{(SIGNED != 0) && b[IN_WIDTH-1]}}, b};
      prod  = a_ext * b_ext;

      sx      = (SIGNED != 0) && p_q[PW-1];
      p_ext   = {{(ACC_WIDTH + 1 - PW){sx}}, p_q};
      acc_ext = {(SIGNED != 0) && acc_q[M], acc_q};
      sum     = acc_ext + p_ext;

      if (SIGNED != 0) begin
         ovf     = (acc_q[M] == p_ext[M]) && (sum[M] != acc_q[M]);
         sat_val = acc_q[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
      end else begin
         ovf     = sum[ACC_WIDTH];
         sat_val = {ACC_WIDTH{1'b1}};
      end

      if ((SATURATE != 0) && ovf) begin
         res = sat_val;
      end else begin
         res = sum[M:0];
      end
   end

   // Next-state for both pipeline stages and the result register
   always_comb begin
      p_d        = p_q;
      p_valid_d  = p_valid_q;
      acc_d      = acc_q;
      ovf_acc_d  = ovf_acc_q;
      cnt_d      = cnt_q;
      out_d      = out_q;
      overflow_d = overflow_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      // clear aborts the vector but leaves any pending result untouched
      if (clear) begin
         p_valid_d = 1'b0;
         acc_d     = {ACC_WIDTH{1'b0}};
         ovf_acc_d = 1'b0;
         cnt_d     = {CW{1'b0}};
      end else if (adv) begin
         p_valid_d = accept;
         if (accept) begin
            p_d = prod;
         end else begin
            p_d = p_q;
         end
         if (p_valid_q) begin
            if (cnt_q == LAST) begin
               out_d       = res;
               overflow_d  = ovf_acc_q | ovf;
               out_valid_d = 1'b1;
               acc_d       = {ACC_WIDTH{1'b0}};
               ovf_acc_d   = 1'b0;
               cnt_d       = {CW{1'b0}};
            end else begin
               acc_d     = res;
               ovf_acc_d = ovf_acc_q | ovf;
               cnt_d     = cnt_q + 16'd1;
            end
         end else begin
            acc_d = acc_q;
         end
      end else begin
         p_valid_d = p_valid_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         p_q         <= {PW{1'b0}};
         p_valid_q   <= 1'b0;
         acc_q       <= {ACC_WIDTH{1'b0}};
         ovf_acc_q   <= 1'b0;
         cnt_q       <= {CW{1'b0}};
         out_q       <= {ACC_WIDTH{1'b0}};
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         p_q         <= p_d;
         p_valid_q   <= p_valid_d;
         acc_q       <= acc_d;
         ovf_acc_q   <= ovf_acc_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign overflow  = overflow_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_unit_pipelined.sv
// Bench for mac_unit_pipelined: four build modes driven by one shared stimulus,
// table-driven vectors, hand-written corner sequences and a random run vs. a reference model.
module tb_mac_unit_pipelined;

   typedef struct packed {
      logic [3:0][7:0]  a;
      logic [3:0][7:0]  b;
      logic [3:0][23:0] o;
      logic [3:0]       f;
   } vec_t;

   typedef struct packed {
      logic [3:0][23:0] o;
      logic [3:0]       f;
   } res_t;

   logic clk = 1'b0;
   logic reset, in_valid, clear, out_ready;
   logic [7:0] a, b;
   logic [3:0] ir, ov, of;
   logic [23:0] o0;
   logic [15:0] o1, o2, o3;
   logic [3:0][23:0] outs;

   logic [3:0] s_ir, s_ov, s_of;
   logic [3:0][23:0] s_outs;
   logic acc_ev, hs_ev;

   int checks = 0;
   int failures = 0;

   vec_t tbl[5];
   logic [15:0] pend[$];
   res_t expq[$];

   always #5 clk = ~clk;

   assign outs[0] = o0;
   assign outs[1] = {8'd0, o1};
   assign outs[2] = {8'd0, o2};
   assign outs[3] = {8'd0, o3};

   mac_unit_pipelined #(.IN_WIDTH(8), .ACC_WIDTH(24), .LEN(4), .SIGNED(0), .SATURATE(0)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .clear(clear),
      .out_valid(ov[0]), .out_ready(out_ready), .out(o0), .overflow(of[0]));
   mac_unit_pipelined #(.IN_WIDTH(8), .ACC_WIDTH(16), .LEN(4), .SIGNED(1), .SATURATE(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .clear(clear),
      .out_valid(ov[1]), .out_ready(out_ready), .out(o1), .overflow(of[1]));
   mac_unit_pipelined #(.IN_WIDTH(8), .ACC_WIDTH(16), .LEN(4), .SIGNED(1), .SATURATE(0)) u2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .clear(clear),
      .out_valid(ov[2]), .out_ready(out_ready), .out(o2), .overflow(of[2]));
   mac_unit_pipelined #(.IN_WIDTH(8), .ACC_WIDTH(16), .LEN(4), .SIGNED(0), .SATURATE(1)) u3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b), .clear(clear),
      .out_valid(ov[3]), .out_ready(out_ready), .out(o3), .overflow(of[3]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_res(input string nm, input logic [3:0][23:0] ao, input logic [3:0] af,
                          input logic [3:0][23:0] eo, input logic [3:0] ef);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_out_u%0d", nm, i), {8'd0, ao[i]}, {8'd0, eo[i]});
         chk($sformatf("%s_ovf_u%0d", nm, i), {31'd0, af[i]}, {31'd0, ef[i]});
      end
   endtask

   // Samples just before the edge (inputs settled), then moves to 1 time unit past it.
   task automatic step();
      #2;
      s_ir   = ir;
      s_ov   = ov;
      s_of   = of;
      s_outs = outs;
      acc_ev = in_valid && ir[0];
      hs_ev  = ov[0] && out_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1; a = 8'd0; b = 8'd0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Reference: plain integer arithmetic with range checks per build mode.
   function automatic logic [24:0] ref_vec(input int m, input logic [3:0][7:0] pa,
                                           input logic [3:0][7:0] pb);
      int w;
      bit sg, sat, ovf;
      longint acc, p, s, lo, hi, md;
      w   = (m == 0) ? 24 : 16;
      sg  = (m == 1) || (m == 2);
      sat = (m == 1) || (m == 3);
      md  = longint'(1) << w;
      lo  = sg ? -(md / 2) : 0;
      hi  = sg ? (md / 2) - 1 : md - 1;
      acc = 0;
      ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (sg) p = longint'($signed(pa[i])) * longint'($signed(pb[i]));
         else    p = longint'(pa[i]) * longint'(pb[i]);
         s = acc + p;
         if (s > hi || s < lo) begin
            ovf = 1'b1;
            if (sat) s = (s > hi) ? hi : lo;
            else begin
               while (s > hi) s = s - md;
               while (s < lo) s = s + md;
            end
         end
         acc = s;
      end
      ref_vec = {ovf, 24'(acc & (md - 1))};
   endfunction

   task automatic rnd_cycle();
      logic [15:0] pr;
      step();
      chk("rnd_in_ready", {28'd0, s_ir}, {28'd0, {4{!s_ov[0] || out_ready}}});
      if (acc_ev) begin
         pend.push_back({a, b});
         if (pend.size() == 4) begin
            res_t e;
            logic [3:0][7:0] pa, pb;
            for (int i = 0; i < 4; i++) begin
               pr = pend[i];
               pa[i] = pr[15:8];
               pb[i] = pr[7:0];
            end
            for (int m = 0; m < 4; m++) begin
               logic [24:0] r;
               r = ref_vec(m, pa, pb);
               e.o[m] = r[23:0];
               e.f[m] = r[24];
            end
            expq.push_back(e);
            pend.delete();
         end
      end
      if (hs_ev) begin
         if (expq.size() == 0) begin
            chk("rnd_unexpected_result", 32'd1, 32'd0);
         end else begin
            res_t e;
            e = expq.pop_front();
            chk_res("rnd", s_outs, s_of, e.o, e.f);
         end
      end
   endtask

   initial begin
      int idx, stall_left, nres;
      bit seen;

      tbl[0].a = {8'd7, 8'd5, 8'd3, 8'd1};  tbl[0].b = {8'd8, 8'd6, 8'd4, 8'd2};
      tbl[0].o = {24'd100, 24'd100, 24'd100, 24'd100};               tbl[0].f = 4'b0000;
      tbl[1].a = {4{8'd127}};               tbl[1].b = {4{8'd127}};
      tbl[1].o = {24'h00FC04, 24'h00FC04, 24'h007FFF, 24'h00FC04};   tbl[1].f = 4'b0110;
      tbl[2].a = {4{8'h80}};                tbl[2].b = {4{8'd127}};
      tbl[2].o = {24'h00FE00, 24'h000200, 24'h008000, 24'h00FE00};   tbl[2].f = 4'b0110;
      tbl[3].a = {4{8'hFF}};                tbl[3].b = {4{8'hFF}};
      tbl[3].o = {24'h00FFFF, 24'd4, 24'd4, 24'h03F804};             tbl[3].f = 4'b1000;
      tbl[4].a = {4{8'h80}};                tbl[4].b = {4{8'h80}};
      tbl[4].o = {24'h00FFFF, 24'h000000, 24'h007FFF, 24'h010000};   tbl[4].f = 4'b1110;

      // reset state
      do_reset();
      chk("rst_in_ready_during", {28'd0, s_ir}, 32'd0);
      chk("rst_out_valid", {28'd0, ov}, 32'd0);
      chk_res("rst", outs, of, '0, 4'b0000);
      step();
      chk("rst_in_ready_after", {28'd0, s_ir}, 32'hF);

      // table-driven single vectors: latency and one-cycle out_valid
      for (int r = 0; r < 5; r++) begin
         do_reset();
         for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; a = tbl[r].a[k]; b = tbl[r].b[k];
            step();
            chk("tbl_in_ready", {28'd0, s_ir}, 32'hF);
         end
         in_valid = 1'b0;
         chk("tbl_lat_early", {28'd0, ov}, 32'd0);
         step();
         chk("tbl_out_valid", {28'd0, ov}, 32'hF);
         chk_res($sformatf("tbl%0d", r), outs, of, tbl[r].o, tbl[r].f);
         step();
         chk("tbl_out_valid_drop", {28'd0, ov}, 32'd0);
      end

      // two back-to-back vectors with no bubble
      do_reset();
      for (int k = 0; k < 12; k++) begin
         if (k < 8) begin
            in_valid = 1'b1; a = 8'(2 * (k % 4) + 1); b = 8'(2 * (k % 4) + 2);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (k < 8) chk("strm_in_ready", {28'd0, s_ir}, 32'hF);
         if (k == 4 || k == 8) begin
            chk("strm_out_valid", {28'd0, ov}, 32'hF);
            chk_res("strm", outs, of, tbl[0].o, 4'b0000);
         end
         if (k == 5) chk("strm_gap", {28'd0, ov}, 32'd0);
      end

      // output stall for 5 cycles after the first result
      do_reset();
      idx = 0; stall_left = 0; nres = 0; seen = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (idx < 8) begin
            in_valid = 1'b1; a = 8'(2 * (idx % 4) + 1); b = 8'(2 * (idx % 4) + 2);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = (stall_left == 0);
         step();
         if (acc_ev) idx++;
         if (stall_left > 0) begin
            chk("stall_in_ready", {28'd0, s_ir}, 32'd0);
            chk("stall_hold", s_outs[0][31 - 8:0], 24'd100);
            stall_left--;
         end
         if (hs_ev) begin
            nres++;
            chk_res("stall_res", s_outs, s_of, tbl[0].o, 4'b0000);
         end
         if (ov[0] && !seen) begin
            seen = 1'b1;
            stall_left = 5;
         end
      end
      chk("stall_accepts", idx, 32'd8);
      chk("stall_results", nres, 32'd2);
      out_ready = 1'b1;

      // clear drops the partial vector and the clear-cycle pair
      do_reset();
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; a = 8'd5; b = 8'd5;
         step();
      end
      clear = 1'b1; a = 8'd9; b = 8'd9;
      step();
      chk("clr_in_ready", {28'd0, s_ir}, 32'd0);
      clear = 1'b0;
      for (int k = 0; k < 4; k++) begin
         a = 8'd1; b = 8'd1;
         step();
      end
      in_valid = 1'b0;
      step();
      chk("clr_out_valid", {28'd0, ov}, 32'hF);
      chk_res("clr", outs, of, {4{24'd4}}, 4'b0000);
      // a pending result survives clear
      out_ready = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_pending_valid", {28'd0, ov}, 32'hF);
      chk_res("clr_pending", outs, of, {4{24'd4}}, 4'b0000);
      out_ready = 1'b1;

      // reset mid-vector with a result pending
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1; a = 8'(2 * (k % 4) + 1); b = 8'(2 * (k % 4) + 2);
         step();
      end
      chk("mid_pending", {28'd0, ov}, 32'hF);
      in_valid = 1'b0; reset = 1'b1;
      step();
      chk("mid_rst_in_ready", {28'd0, s_ir}, 32'd0);
      chk("mid_rst_valid", {28'd0, ov}, 32'd0);
      chk_res("mid_rst", outs, of, '0, 4'b0000);
      reset = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; a = 8'd2; b = 8'd3;
         step();
         if (k == 0) chk("mid_first_ready", {28'd0, s_ir}, 32'hF);
      end
      in_valid = 1'b0;
      step();
      chk("mid_new_valid", {28'd0, ov}, 32'hF);
      chk_res("mid_new", outs, of, {4{24'd24}}, 4'b0000);

      // random stream against the reference model
      do_reset();
      pend.delete();
      expq.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a = 8'($urandom);
         b = 8'($urandom);
         rnd_cycle();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) rnd_cycle();
      chk("rnd_drained", expq.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
